// File: rtl/spi_target_if.sv
// Decoupled valid/ready byte channel between the SPI target and the CPU side.
interface spi_target_if #(
  parameter int W = 8
);
  logic         valid;
  logic         ready;
  logic [W-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/spi_target.sv
// SPI target endpoint: oversampled SCLK/CS_n/MOSI, modes 0-3,
// one-entry TX buffer and a single RX holding register.
module spi_target #(
  parameter logic [7:0]  FillByte   = 8'hFF,
  parameter int unsigned SyncStages = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_sclk,
  input  logic         i_cs_n,
  input  logic         i_mosi,
  output logic         o_miso,
  output logic         o_miso_oe,
  input  logic [1:0]   i_spi_mode,
  spi_target_if.slave  if_txd,
  spi_target_if.master if_rxd,
  output logic         o_underrun,
  output logic         o_overrun,
  output logic         o_busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SyncStages-1:0] sclk_sq, cs_sq, mosi_sq;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sclk_sq     <= '0;
      cs_sq       <= '1;
      mosi_sq     <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sq     <= {sclk_sq[SyncStages-2:0], i_sclk};
      cs_sq       <= {cs_sq[SyncStages-2:0], i_cs_n};
      mosi_sq     <= {mosi_sq[SyncStages-2:0], i_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s = sclk_sq[SyncStages-1];
  assign cs_s   = cs_sq[SyncStages-1];
  assign mosi_s = mosi_sq[SyncStages-1];

  state_t     state_q, state_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic       pend_q, pend_d;
  logic [7:0] txb_q, txb_d;
  logic       txb_vld_q, txb_vld_d;
  logic [7:0] rxb_q, rxb_d;
  logic       rxb_vld_q, rxb_vld_d;
  logic       unr_q, unr_d;
  logic       ovr_q, ovr_d;

  logic       cs_fall, cs_rise;
  logic       lead_e, trail_e;
  logic       samp_e, shift_e;
  logic       load;
  logic [7:0] rx_nxt;

  assign cs_fall = cs_prev_q && !cs_s;
  assign cs_rise = !cs_prev_q && cs_s;
  assign lead_e  = (sclk_s ^ sclk_prev_q) && (sclk_s != cpol_q);
  assign trail_e = (sclk_s ^ sclk_prev_q) && (sclk_s == cpol_q);
  assign samp_e  = cpha_q ? trail_e : lead_e;
  assign shift_e = cpha_q ? lead_e : trail_e;
  assign rx_nxt  = {rx_q[6:0], mosi_s};

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    pend_d    = pend_q;
    txb_d     = txb_q;
    txb_vld_d = txb_vld_q;
    rxb_d     = rxb_q;
    rxb_vld_d = rxb_vld_q;
    unr_d     = 1'b0;
    ovr_d     = 1'b0;
    load      = 1'b0;

    if (if_txd.valid && !txb_vld_q) begin
      txb_d     = if_txd.bits;
      txb_vld_d = 1'b1;
    end
    if (rxb_vld_q && if_rxd.ready) begin
      rxb_vld_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (cs_fall) begin
          cpol_d  = i_spi_mode[1];
          cpha_d  = i_spi_mode[0];
          first_d = 1'b1;
          load    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
          first_d = 1'b0;
        end else if (samp_e) begin
          rx_d  = rx_nxt;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            pend_d = 1'b1;
            // a byte completing as the old one is consumed still lands
            if (!rxb_vld_q || if_rxd.ready) begin
              rxb_d     = rx_nxt;
              rxb_vld_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else if (shift_e) begin
          first_d = 1'b0;
          if (!(first_q && cpha_q)) begin
            if (pend_q) begin
              load   = 1'b1;
              pend_d = 1'b0;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (txb_vld_q) begin
        tx_d      = txb_q;
        txb_vld_d = 1'b0;
      end else begin
        tx_d  = FillByte;
        unr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      pend_q    <= 1'b0;
      txb_q     <= '0;
      txb_vld_q <= 1'b0;
      rxb_q     <= '0;
      rxb_vld_q <= 1'b0;
      unr_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      pend_q    <= pend_d;
      txb_q     <= txb_d;
      txb_vld_q <= txb_vld_d;
      rxb_q     <= rxb_d;
      rxb_vld_q <= rxb_vld_d;
      unr_q     <= unr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_miso       = tx_q[7];
  assign o_miso_oe    = (state_q == ACTIVE);
  assign o_busy       = (state_q == ACTIVE);
  assign o_underrun   = unr_q;
  assign o_overrun    = ovr_q;
  assign if_txd.ready = !txb_vld_q;
  assign if_rxd.valid = rxb_vld_q;
  assign if_rxd.bits  = rxb_q;

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI target (slave) endpoint. The external initiator drives SCLK, CS_n and MOSI; this block returns MISO.
- Oversamples all SPI pins in the i_clk domain. Received bytes go to the CPU side over a Decoupled sender; bytes to return come from a Decoupled receiver.
- Supports SPI modes 0–3, selected per transaction.
- Sits beside the existing SPI initiator so one FPGA can act as an SPI peripheral to an external host.

Parameters:
- FillByte, 8'hFF, byte shifted out when no TX byte is queued at a byte boundary.
- SyncStages, 2, synchronizer depth for i_sclk, i_cs_n and i_mosi; legal values 2–3.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst  input  1  reset, synchronous, active-low (0 = reset).
- i_sclk  input  1  SPI clock from initiator, asynchronous.
- i_cs_n  input  1  chip select, active-low, asynchronous.
- i_mosi  input  1  serial data in, asynchronous.
- o_miso  output  1  serial data out; equals bit 7 of the TX shift register.
- o_miso_oe  output  1  MISO output enable; 1 only while the block is in ACTIVE.
- i_spi_mode  input  2  {cpol, cpha}; latched at CS_n assertion.
- if_txd  Decoupled.receiver  8  next byte to return to the initiator.
- if_rxd  Decoupled.sender  8  byte received from the initiator.
- o_underrun  output  1  1-cycle pulse: FillByte was loaded because the TX buffer was empty.
- o_overrun  output  1  1-cycle pulse: a received byte was dropped because if_rxd was still valid.
- o_busy  output  1  1 while in ACTIVE.

Behaviour:
- Reset values (i_rst=0 at posedge):
  - state=IDLE; o_miso=0; o_miso_oe=0; o_busy=0.
  - if_rxd.valid=0; TX buffer empty, so if_txd.ready=1.
  - o_underrun=0; o_overrun=0.
  - Synchronizers preset: sclk=0, cs_n=1.
  - Reset mid-transfer aborts immediately. No rxd is produced and the partial byte is lost.
- Synchronization and edge detection:
  - Each pin passes through SyncStages flops, plus one extra flop on sclk and cs_n for edge detection.
  - A pin transition is acted on SyncStages+1 i_clk cycles after it occurs.
  - Supported SCLK frequency is at most i_clk/8.
- Edge classification:
  - leading edge = sync'd sclk leaves cpol.
  - trailing edge = sync'd sclk returns to cpol.
  - sample edge = leading if cpha=0, trailing if cpha=1.
  - shift edge = the opposite edge.
- TX buffer:
  - One-entry register. if_txd.ready = !tx_buf_valid.
  - A transfer occurs on valid&&ready.
  - The buffer empties when its byte is loaded into the shift register.
  - Load and a new accept in the same cycle are not possible, because ready is low while the buffer is full.
- State IDLE:
  - o_miso_oe=0; bit_cnt=0.
  - On a sync'd cs_n falling edge:
    - Latch cpol/cpha from i_spi_mode.
    - Load tx_shift from the TX buffer, or from FillByte with an o_underrun pulse if the buffer is empty.
    - Set first=1 and go to ACTIVE.
- State ACTIVE:
  - o_miso_oe=1; o_busy=1.
  - Sample edge: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
  - Shift edge:
    - If first=1 and cpha=1: no shift; first<=0. The bit 7 loaded at CS is already on MISO.
    - Else if a byte boundary is pending: load the next byte (same underrun rule as IDLE) and clear the pending flag.
    - Else: tx_shift <= {tx_shift[6:0], 0}.
    - Clear first on the first shift edge in every mode.
  - On the 8th sample (bit_cnt 7→0 wrap, 3-bit counter):
    - Set the byte-boundary pending flag.
    - If if_rxd.valid=0, set if_rxd.bits=byte and if_rxd.valid=1 on the next posedge.
    - Else drop the byte and pulse o_overrun. The old byte is kept.
  - if_rxd.valid clears on valid&&ready.
  - Simultaneous completion of a new byte and consumption in the same cycle: the new byte is accepted and valid stays 1.
- CS_n deassert (sync'd rising edge) in any ACTIVE cycle:
  - Go to IDLE; o_miso_oe=0.
  - A partial rx byte (bit_cnt≠0) is discarded; bit_cnt=0.
  - A byte already loaded into tx_shift is consumed, not restored.
  - CS deassert in the same cycle as a sample edge: the CS deassert wins and the sample is ignored.
- SCLK edges while in IDLE are ignored.

Test Plan:
- Mode 0, txd=0x3C queued, initiator sends 0xA5 → rxd=0xA5 with one valid; MISO bits 0,0,1,1,1,1,0,0; if_txd.ready returns to 1 after CS assert.
- Mode 3, txd=0x81, initiator sends 0x5A → rxd=0x5A; MISO sampled by initiator on rising edges = 0x81.
- Mode 1, two back-to-back bytes (0x11, 0x22) with only txd=0xC3 queued → MISO returns 0xC3 then 0xFF; one o_underrun pulse at the second byte; rxd stream 0x11, 0x22.
- Hold if_rxd.ready=0, send 0x01 then 0x02 → rxd.bits stays 0x01; one o_overrun pulse; after ready → a single transfer of 0x01.
- Mode 2, deassert CS after 5 SCLK periods of 0xFF, then a full byte 0x7E → no rxd for the partial byte; next rxd=0x7E; o_miso_oe low between the transactions.
- Assert i_rst=0 mid-byte with txd queued → all outputs at reset values next cycle; if_txd.ready=1; no rxd produced.
